// File: rtl/qe_multi_decoder_pkg.sv
// qe_pkg: register map, CONFIG/STATUS bit positions and quadrature step decode shared by qe_multi_decoder
package qe_pkg;
  localparam logic [2:0] OFF_POS  = 3'd0;
  localparam logic [2:0] OFF_CAP  = 3'd1;
  localparam logic [2:0] OFF_CMP  = 3'd2;
  localparam logic [2:0] OFF_CFG  = 3'd3;
  localparam logic [2:0] OFF_STAT = 3'd4;
  localparam int CFG_EN   = 0;
  localparam int CFG_SWAP = 1;
  localparam int CFG_INV  = 2;
  localparam int CFG_ICLR = 3;
  localparam int CFG_MASK = 4;
  localparam int ST_CAP   = 0;
  localparam int ST_MATCH = 1;
  localparam int ST_ERR   = 2;
  localparam int ST_IN    = 4;
  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ERR} qe_step_t;
  // {a,b} forward order 00->10->11->01 maps to phase index {b, a^b} = 0..3,
  // so the modulo-4 phase difference gives the step directly.
  function automatic qe_step_t qe_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] d;
    d = {cur_ab[0], ^cur_ab} - {prev_ab[0], ^prev_ab};
    return d == 2'd1 ? STEP_UP : d == 2'd3 ? STEP_DOWN : d == 2'd2 ? STEP_ERR : STEP_NONE;
  endfunction
endpackage

// File: rtl/qe_multi_decoder_if.sv
// qe_multi_decoder_if: subsystem register port (addr, wr/rd strobes, wdata, rdata/rvalid)
interface qe_multi_decoder_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr;
  logic              reg_rd;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic              reg_rvalid;
  modport master(output reg_addr, reg_wr, reg_rd, reg_wdata, input reg_rdata, reg_rvalid);
  modport slave(input reg_addr, reg_wr, reg_rd, reg_wdata, output reg_rdata, reg_rvalid);
endinterface

// File: rtl/qe_multi_decoder_input_filter.sv
// qe_input_filter: two-flop synchroniser plus optional glitch filter for one encoder input
// Ports: clk, reset (async active-low), d (async input), q (filtered output).
// QE_GLITCH_FILTER_EN: q follows the synchronised value only after FILT_DEPTH
// consecutive differing samples; otherwise q is the synchronised value.
module qe_input_filter #(parameter int FILT_DEPTH = 4) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= '0;
    else sync <= {sync[0], d};
`ifdef QE_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_DEPTH);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      q <= 1'b0;
    end else if (sync[1] == q) cnt <= '0;
    else if (cnt == CW'(FILT_DEPTH - 1)) begin
      q <= sync[1];
      cnt <= '0;
    end else cnt <= cnt + CW'(1);
`else
  localparam int unused_depth = FILT_DEPTH;
  assign q = sync[1];
`endif
endmodule

// File: rtl/qe_multi_decoder.sv
// qe_multi_decoder: NUM_CH-channel 4x quadrature decoder with capture, compare, phase-error flags and irq
// Ports: clk, reset (async active-low), bus (register slave port), qe_a/qe_b/qe_i
// (async encoder inputs, one bit per channel), irq (level, OR of masked flags).
// QE_GLITCH_FILTER_EN enables the per-input glitch filter in qe_input_filter.
module qe_multi_decoder
  import qe_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int FILT_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  qe_multi_decoder_if.slave   bus,
  input  logic [NUM_CH-1:0]   qe_a,
  input  logic [NUM_CH-1:0]   qe_b,
  input  logic [NUM_CH-1:0]   qe_i,
  output logic                irq
);
  logic [ADDR_W-4:0] ch_sel;
  logic [2:0]        off;
  logic [31:0]       ch_rd [NUM_CH];
  logic [NUM_CH-1:0] ch_irq;
  logic [31:0]       rd_mux;
  assign ch_sel = bus.reg_addr[ADDR_W-1:3];
  assign off    = bus.reg_addr[2:0];
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic a_f, b_f, i_f, prev_i, wr_ch, idx_rise, clr, up, dn;
    logic [1:0] prev_ab, ab_c, ab_p;
    logic [CNT_W-1:0] pos, cap, cmp, pos_n;
    logic [6:0] cfg;
    logic [2:0] flg, set;
    qe_step_t st;
    qe_input_filter #(.FILT_DEPTH(FILT_DEPTH)) u_a (.clk, .reset, .d(qe_a[n]), .q(a_f));
    qe_input_filter #(.FILT_DEPTH(FILT_DEPTH)) u_b (.clk, .reset, .d(qe_b[n]), .q(b_f));
    qe_input_filter #(.FILT_DEPTH(FILT_DEPTH)) u_i (.clk, .reset, .d(qe_i[n]), .q(i_f));
    assign wr_ch = bus.reg_wr & (ch_sel == (ADDR_W-3)'(n));
    // prev_ab holds raw {a,b}; swap is applied to both sides so toggling CONFIG[1] never fakes a step
    assign ab_c = cfg[CFG_SWAP] ? {b_f, a_f} : {a_f, b_f};
    assign ab_p = cfg[CFG_SWAP] ? {prev_ab[0], prev_ab[1]} : prev_ab;
    assign st = qe_decode(ab_p, ab_c);
    assign up = cfg[CFG_EN] & (st == (cfg[CFG_INV] ? STEP_DOWN : STEP_UP));
    assign dn = cfg[CFG_EN] & (st == (cfg[CFG_INV] ? STEP_UP : STEP_DOWN));
    assign idx_rise = cfg[CFG_EN] & i_f & ~prev_i;
    assign clr = idx_rise & cfg[CFG_ICLR];
    assign pos_n = wr_ch & (off == OFF_POS) ? bus.reg_wdata[CNT_W-1:0] :
                   clr ? '0 : up ? pos + CNT_W'(1) : dn ? pos - CNT_W'(1) : pos;
    always_comb begin
      set = '0;
      set[ST_CAP] = idx_rise;
      set[ST_MATCH] = (up | dn | clr) & (pos_n == cmp);
      set[ST_ERR] = cfg[CFG_EN] & (st == STEP_ERR);
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        prev_ab <= '0;
        prev_i <= 1'b0;
        pos <= '0;
        cap <= '0;
        cmp <= '0;
        cfg <= '0;
        flg <= '0;
      end else begin
        prev_ab <= {a_f, b_f};
        prev_i <= i_f;
        pos <= pos_n;
        if (idx_rise) cap <= pos;
        if (wr_ch && off == OFF_CMP) cmp <= bus.reg_wdata[CNT_W-1:0];
        if (wr_ch && off == OFF_CFG) cfg <= bus.reg_wdata[6:0];
        flg <= (flg & ~(wr_ch && off == OFF_STAT ? bus.reg_wdata[2:0] : 3'b0)) | set;
      end
    assign ch_irq[n] = |(flg & cfg[CFG_MASK +: 3]);
    assign ch_rd[n] = off == OFF_POS  ? 32'($signed(pos)) :
                      off == OFF_CAP  ? 32'($signed(cap)) :
                      off == OFF_CMP  ? 32'($signed(cmp)) :
                      off == OFF_CFG  ? 32'(cfg) :
                      off == OFF_STAT ? (32'({i_f, b_f, a_f}) << ST_IN) | 32'(flg) : '0;
  end
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_sel == (ADDR_W-3)'(k)) rd_mux = ch_rd[k];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.reg_rdata <= '0;
      bus.reg_rvalid <= 1'b0;
    end else begin
      bus.reg_rvalid <= bus.reg_rd;
      if (bus.reg_rd) bus.reg_rdata <= rd_mux;
    end
  assign irq = |ch_irq;
endmodule

// File: tb/tb_qe_multi_decoder.sv
// tb_qe_multi_decoder: vector table plus hand sequences, reads checked through an rdata scoreboard
module tb_qe_multi_decoder;
`ifdef QE_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  qe_multi_decoder_if #(.ADDR_W(8)) bus0 ();
  qe_multi_decoder_if #(.ADDR_W(8)) bus1 ();
  logic [3:0] qa0 = '0, qb0 = '0, qi0 = '0;
  logic [1:0] qa1 = '0, qb1 = '0, qi1 = '0;
  logic irq0, irq1;
  qe_multi_decoder #(.NUM_CH(4), .CNT_W(32), .FILT_DEPTH(4), .ADDR_W(8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .qe_a(qa0), .qe_b(qb0), .qe_i(qi0), .irq(irq0));
  qe_multi_decoder #(.NUM_CH(2), .CNT_W(16), .FILT_DEPTH(4), .ADDR_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .qe_a(qa1), .qe_b(qb1), .qe_i(qi1), .irq(irq1));

  typedef struct {logic [31:0] exp; string nm;} sb_t;
  typedef struct {int d; bit wr; logic [7:0] addr; logic [31:0] wdata; logic [31:0] exp;} vec_t;
  sb_t sb[$];
  vec_t vt[14];
  int tests = 0, fails = 0, ph0 = 0, ph1 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL rvalid_unexpected: got rdata %h with no read pending", act);
    end else begin
      e = sb.pop_front();
      chk(e.nm, act, e.exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.reg_rvalid) sb_pop(bus0.reg_rdata);
    if (bus1.reg_rvalid) sb_pop(bus1.reg_rdata);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv(input int d, input logic w, input logic r, input logic [7:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.reg_wr = w; bus0.reg_rd = r; bus0.reg_addr = a; bus0.reg_wdata = wd;
    end else begin
      bus1.reg_wr = w; bus1.reg_rd = r; bus1.reg_addr = a; bus1.reg_wdata = wd;
    end
  endtask

  task automatic acc(input int d, input logic w, input logic r, input logic [7:0] a,
                     input logic [31:0] wd, input logic [31:0] e, input string nm);
    drv(d, w, r, a, wd);
    if (r) sb.push_back('{e, nm});
    @(negedge clk);
    drv(d, 1'b0, 1'b0, a, wd);
  endtask

  task automatic wr(input int d, input logic [7:0] a, input logic [31:0] wd);
    acc(d, 1'b1, 1'b0, a, wd, 32'h0, "");
  endtask

  task automatic rd(input int d, input logic [7:0] a, input logic [31:0] e, input string nm);
    acc(d, 1'b0, 1'b1, a, 32'h0, e, nm);
  endtask

  function automatic logic [1:0] gray(input int p);
    return {p == 1 || p == 2, p >= 2};
  endfunction

  task automatic step(input int d, input int dir);
    if (d == 0) begin
      ph0 = (ph0 + dir) & 3;
      {qa0[0], qb0[0]} = gray(ph0);
    end else begin
      ph1 = (ph1 + dir) & 3;
      {qa1[1], qb1[1]} = gray(ph1);
    end
  endtask

  function automatic logic [31:0] stat0(input logic [2:0] f);
    return {25'b0, qi0[0], qb0[0], qa0[0], 1'b0, f};
  endfunction

  task automatic rst_pulse();
    reset = 1'b0;
    wait_cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    drv(0, 1'b0, 1'b0, 8'h0, 32'h0);
    drv(1, 1'b0, 1'b0, 8'h0, 32'h0);
    vt = '{
      '{0, 1'b0, 8'h00, 32'h0,        32'h0},
      '{0, 1'b0, 8'h04, 32'h0,        32'h0},
      '{0, 1'b1, 8'h00, 32'h12345678, 32'h12345678},
      '{0, 1'b1, 8'h02, 32'hDEADBEEF, 32'hDEADBEEF},
      '{0, 1'b1, 8'h03, 32'hFFFFFFF0, 32'h00000070},
      '{0, 1'b1, 8'h1A, 32'h000000A5, 32'h000000A5},
      '{0, 1'b0, 8'h05, 32'h0,        32'h0},
      '{0, 1'b0, 8'h07, 32'h0,        32'h0},
      '{0, 1'b0, 8'h20, 32'h0,        32'h0},
      '{0, 1'b1, 8'h01, 32'h00000055, 32'h0},
      '{0, 1'b1, 8'h04, 32'h00000077, 32'h0},
      '{1, 1'b1, 8'h08, 32'h00012345, 32'h00002345},
      '{1, 1'b1, 8'h08, 32'h00008000, 32'hFFFF8000},
      '{1, 1'b0, 8'h10, 32'h0,        32'h0}
    };
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(2);
    foreach (vt[k]) begin
      if (vt[k].wr) wr(vt[k].d, vt[k].addr, vt[k].wdata);
      rd(vt[k].d, vt[k].addr, vt[k].exp, $sformatf("vec%0d", k));
    end
    rst_pulse();
    rd(0, 8'h00, 32'h0, "reset_pos");
    chk("reset_irq", {31'b0, irq0}, 32'h0);
    // counting and wrap
    wr(0, 8'h03, 32'h1);
    for (int k = 0; k < 32; k++) begin step(0, 1); wait_cyc(10); end
    rd(0, 8'h00, 32'd32, "pos_fwd32");
    for (int k = 0; k < 32; k++) begin step(0, -1); wait_cyc(10); end
    rd(0, 8'h00, 32'h0, "pos_rev0");
    step(0, -1);
    wait_cyc(10);
    rd(0, 8'h00, 32'hFFFFFFFF, "pos_wrap");
    // short glitch on A, then exact latency of a clean edge
    qa0[0] = 1'b1;
    wait_cyc(3);
    qa0[0] = 1'b0;
    wait_cyc(12);
    rd(0, 8'h00, 32'hFFFFFFFF, "glitch_reject");
    step(0, 1);
    wait_cyc(LAT - 1);
    rd(0, 8'h00, 32'hFFFFFFFF, "lat_before");
    rd(0, 8'h00, 32'h0, "lat_after");
    // phase error and irq
    wr(0, 8'h04, 32'h7);
    wr(0, 8'h03, 32'h41);
    qa0[0] = 1'b1;
    qb0[0] = 1'b1;
    ph0 = 2;
    wait_cyc(10);
    rd(0, 8'h00, 32'h0, "err_nocount");
    rd(0, 8'h04, stat0(3'b100), "err_status");
    chk("irq_set", {31'b0, irq0}, 32'h1);
    wr(0, 8'h04, 32'h4);
    chk("irq_clr", {31'b0, irq0}, 32'h0);
    acc(0, 1'b1, 1'b1, 8'h02, 32'h1234, 32'h0, "rdwr_old");
    rd(0, 8'h02, 32'h1234, "rdwr_new");
    // index capture with clear
    wr(0, 8'h02, 32'd5);
    wr(0, 8'h00, 32'd100);
    wr(0, 8'h03, 32'h09);
    wr(0, 8'h04, 32'h7);
    qi0[0] = 1'b1;
    wait_cyc(10);
    qi0[0] = 1'b0;
    wait_cyc(10);
    rd(0, 8'h01, 32'd100, "cap_val");
    rd(0, 8'h00, 32'h0, "idx_clr");
    rd(0, 8'h04, stat0(3'b001), "cap_flag");
    // compare match timing
    wr(0, 8'h03, 32'h1);
    wr(0, 8'h04, 32'h7);
    for (int k = 0; k < 4; k++) begin step(0, 1); wait_cyc(10); end
    rd(0, 8'h04, stat0(3'b000), "match_pre");
    step(0, 1);
    wait_cyc(LAT - 1);
    rd(0, 8'h04, stat0(3'b000), "match_edge0");
    rd(0, 8'h04, stat0(3'b010), "match_set");
    rd(0, 8'h00, 32'd5, "pos5");
    // host write on the same edge as a count step
    step(0, 1);
    wait_cyc(LAT - 1);
    wr(0, 8'h00, 32'h200);
    wait_cyc(10);
    rd(0, 8'h00, 32'h200, "wr_priority");
    wr(0, 8'h03, 32'h0);
    step(0, 1);
    wait_cyc(10);
    rd(0, 8'h00, 32'h200, "disabled_hold");
    // second instance: channel isolation and 16-bit sign extension
    wr(1, 8'h03, 32'h1);
    wr(1, 8'h0B, 32'h1);
    wr(1, 8'h08, 32'h7FFF);
    step(1, 1);
    wait_cyc(10);
    rd(1, 8'h08, 32'hFFFF8000, "c16_wrap");
    rd(1, 8'h00, 32'h0, "ch0_pos_untouched");
    rd(1, 8'h04, 32'h0, "ch0_stat_untouched");
    // asynchronous reset in the middle of operation
    wr(0, 8'h03, 32'h41);
    qa0[0] = ~qa0[0];
    qb0[0] = ~qb0[0];
    ph0 = 3;
    wait_cyc(LAT + 2);
    chk("irq_pre_rst", {31'b0, irq0}, 32'h1);
    #2 reset = 1'b0;
    #1 chk("rst_irq_async", {31'b0, irq0}, 32'h0);
    wait_cyc(2);
    reset = 1'b1;
    rd(0, 8'h00, 32'h0, "rst_pos");
    rd(0, 8'h03, 32'h0, "rst_cfg");
    wait_cyc(3);
    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qe_multi_decoder.md
# qe_multi_decoder

Parametrised multi-channel quadrature encoder decoder, successor to the single-channel encoder unit. Each of NUM_CH channels synchronises and optionally glitch-filters external A/B/I inputs. It performs 4x decoding into a CNT_W-bit wrapping position counter, captures position on index, flags compare matches and illegal transitions, and raises a maskable interrupt. The block sits on the subsystem register port behind the bus wrapper.

## Interface
- NUM_CH, 4: number of encoder channels (1..8).
- CNT_W, 32: position/capture/compare width (8..32).
- FILT_DEPTH, 4: consecutive stable samples required by the glitch filter (2..16).
- ADDR_W, 8: register address width; channel n occupies addresses n*8 .. n*8+4.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- reg_addr  in  ADDR_W  register address.
- reg_wr  in  1  write strobe, one cycle.
- reg_rd  in  1  read strobe, one cycle.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid with reg_rvalid; reset 0.
- reg_rvalid  out  1  pulses one cycle after reg_rd; reset 0.
- qe_a, qe_b, qe_i  in  NUM_CH  asynchronous encoder inputs.
- irq  out  1  level interrupt; reset 0.

## Operation
- Registers per channel, at offset from n*8:
  - 0 POSITION (R/W): a write loads the counter.
  - 1 CAPTURE (R).
  - 2 COMPARE (R/W).
  - 3 CONFIG (R/W).
  - 4 STATUS (R, W1C on bits 2:0).
- CNT_W values are sign-extended on read. Upper write bits are ignored.
- Reads of unmapped offsets return 0.
- CONFIG bits:
  - 0 enable.
  - 1 swap A/B.
  - 2 invert direction.
  - 3 clear position on index.
  - 6:4 irq mask for STATUS 2:0.
- STATUS bits:
  - 0 capture valid.
  - 1 compare match.
  - 2 phase error.
  - 6:4 filtered {I,B,A}.
- Decoder compares the registered previous filtered {A,B} with the current value:
  - Gray-code step forward: +1.
  - Gray-code step backward: −1.
  - Both bits changed: no count; set phase error.
  - Direction is inverted when CONFIG[2] is set.
- Counter wraps modulo 2^CNT_W in both directions.
- Rising edge of filtered I: CAPTURE <= position value before any same-cycle update; set capture valid. If CONFIG[3] is set, position <= 0.
- Compare match sets when the updated position equals COMPARE. The flag is sticky.
- A disabled channel holds position and does not update flags. Synchroniser and filter keep running.
- irq = OR over channels of (STATUS[2:0] & CONFIG[6:4]).

Same-cycle priority on the position counter, highest first:
1. Host write to POSITION.
2. Index clear.
3. Count step.

- W1C and a same-cycle flag set: set wins.

## Timing
- Synchroniser: two flops.
- Filter per signal: counter of consecutive samples where the synchronised value differs from the filtered value. On reaching FILT_DEPTH, filtered <= synchronised and the counter resets. Any sample equal to the filtered value resets the counter.
- Latency, input edge to POSITION update: 2 + FILT_DEPTH + 1 cycles. Index capture has the same latency.
- Pulses shorter than FILT_DEPTH cycles after synchronisation are rejected.
- Register write takes effect at the next edge.
- Read data reflects state at the reg_rd edge. rvalid is asserted the following cycle.
- reg_rd and reg_wr asserted together: the write is performed and the read returns the old value.
- Reset mid-operation: all registers, filters and flags clear asynchronously. Filtered inputs reset to 0, and the previous-AB register resets to 00.

## Configuration
- QE_GLITCH_FILTER_EN defined: the filter is instantiated as above.
- QE_GLITCH_FILTER_EN undefined:
  - Filtered signal = synchronised signal.
  - Latency drops to 3 cycles.
  - FILT_DEPTH is ignored.
  - No pulse rejection.

## Structure
- qe_pkg holds:
  - register offset constants;
  - CONFIG/STATUS bit positions;
  - qe_step_t enum {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ERR};
  - decode function mapping {prev_ab, cur_ab} to qe_step_t.
- Sub-module qe_input_filter: one signal, two-flop sync plus optional filter. Instantiated 3×NUM_CH times.

## Test plan
- FILT_DEPTH=4, channel 0 enabled, 8 forward quadrature cycles (32 edges), 10 clk per phase -> POSITION=32; reversing -> POSITION returns 0; one more reverse step -> 0xFFFFFFFF.
- 3-cycle glitch on qe_a -> POSITION unchanged. 4-cycle-stable edge -> step counted after 7 cycles.
- A and B toggled in the same cycle -> no count, STATUS[2]=1. irq=1 with CONFIG[6]=1. W1C 0x4 -> irq=0.
- POSITION=100, CONFIG[3]=1, index pulse -> CAPTURE=100, POSITION=0, STATUS[0]=1.
- COMPARE=5, count up from 0 -> STATUS[1] sets exactly when POSITION becomes 5; host write of POSITION same cycle as a count step -> written value retained.
- NUM_CH=2: stimulus on channel 1 only -> channel 0 registers unchanged. CNT_W=16 at 0x7FFF plus one step -> reads 0xFFFF8000.
